booth_mul_sequencer: RTL
========================

// Module: booth_mul_sequencer
// PURPOSE
//  Upstream front-end of the Booth multiplier. Accepts signed operand pairs over a valid/ready
//  handshake and buffers them in a small FIFO. Issues one operation at a time to the Booth
//  controller/datapath by driving a 1-cycle start pulse and holding the operands stable.
//  Captures the product on the done pulse and presents it on a valid/ready result port.
// PARAMETERS
//  WIDTH      8   operand width (bits); product is 2*WIDTH, signed two's complement
//  FIFO_DEPTH 2   operand FIFO entries; power of two, >=2
//  TIMEOUT    40  max cycles from the mul_start cycle to mul_done before abort
// PORTS
//  clk         in   1        clock, rising edge
//  rst_n       in   1        asynchronous active-low reset
//  in_valid    in   1        operand pair valid
//  in_ready    out  1        FIFO can accept (= !full)
//  in_mcand    in   WIDTH    multiplicand (signed)
//  in_mplier   in   WIDTH    multiplier (signed)
//  mul_start   out  1        start pulse to Booth controller
//  mul_mcand   out  WIDTH    multiplicand to datapath M; stable from start until done
//  mul_mplier  out  WIDTH    multiplier to datapath Q; stable from start until done
//  mul_done    in   1        1-cycle done pulse from Booth controller
//  mul_product in   2*WIDTH  {A,Q} product from datapath; valid only in the mul_done cycle
//  out_valid   out  1        result valid; held until out_ready
//  out_ready   in   1        consumer accepts result
//  out_product out  2*WIDTH  registered product
//  busy        out  1        FIFO non-empty OR state!=IDLE OR out_valid
//  err         out  1        sticky timeout flag; cleared only by reset
// BEHAVIOUR
//  Reset (async, rst_n low): FIFO emptied; state=IDLE; mul_start, out_valid, err, in_ready,
//   busy = 0. out_product, mul_mcand, mul_mplier = 0. in_ready = 1 from the first cycle after release.
//  Input: push when in_valid&&in_ready. No write when full. No input->issue bypass.
//  FSM: IDLE, ISSUE, WAIT.
//   IDLE: pop when FIFO non-empty AND (!out_valid OR out_ready). The popped entry loads the
//    mul_mcand/mul_mplier regs; state->ISSUE. out_valid=0 is required at issue, so the
//    output reg is always free at done.
//   ISSUE: mul_start=1 for exactly this cycle. Timeout counter cleared; state->WAIT.
//   WAIT: counter increments each cycle.
//    On mul_done: out_product<=mul_product; out_valid<=1; state->IDLE.
//    Counter reaches TIMEOUT without done: err<=1; op dropped (no out_valid); state->IDLE.
//  mul_done outside WAIT is ignored. No FSM, FIFO or output change.
//  Output: out_valid clears on out_valid&&out_ready unless a new result is loaded in the same
//   cycle; out_product is held stable while out_valid && !out_ready.
//  Latency: accept at cycle t -> mul_start at t+2 (idle, FIFO empty, output free) ->
//   out_valid the cycle after mul_done.
//  Simultaneous push+pop: allowed whenever not full; occupancy unchanged.
//  FIFO pointers wrap modulo FIFO_DEPTH. full/empty use an extra pointer bit.
//  Arithmetic: product passes through unmodified (no sign fix-up); widths exact, no truncation.
// CONFIGURATION
//  BOOTH_SEQ_ZERO_BYPASS_EN defined: in IDLE, if the popped entry has either operand == 0,
//   no mul_start is issued. Next cycle out_product=0 and out_valid=1; state stays IDLE.
//   No timeout counting for such ops.
//  Not defined: every op, including zero operands, goes through ISSUE/WAIT.
// TESTING (WIDTH=8, FIFO_DEPTH=2, TIMEOUT=40; bench models controller with done N cycles after start)
//  1 accept 7 x -3 at t -> mul_start=1 only at t+2, mul_mcand=8'h07/mul_mplier=8'hFD stable to
//    done; model returns 16'hFFEB -> out_product=16'hFFEB, out_valid held until out_ready.
//  2 out_ready=0, push 3 ops back-to-back -> second not issued while out_valid=1; in_ready=0
//    with 2 entries queued. Drain -> results emitted in order, no loss or duplication.
//  3 model never asserts done -> err=1 exactly 40 cycles after the mul_start cycle, no out_valid;
//    next op completes normally and err stays 1.
//  4 rst_n low during WAIT -> immediately out_valid=0, mul_start=0, err=0, busy=0; a done
//    pulse after release is ignored.
//  5 0 x 8'h37: with BOOTH_SEQ_ZERO_BYPASS_EN -> out_valid with 16'h0000, no mul_start;
//    without it -> normal mul_start/done path.
//  6 mul_done pulsed while IDLE with FIFO empty -> no out_valid, busy stays 0.

Source files
------------

// File: rtl/booth_mul_sequencer_if.sv
// rtl/booth_mul_sequencer_if.sv - operand, controller and result signals of the Booth multiplier front-end
//
// Purpose: bundles the three handshakes of booth_mul_sequencer.
//   slave  : the sequencer's view.
//   master : the surrounding environment (producer, Booth controller, consumer).
// Signals:
//   in_valid/in_ready/in_mcand/in_mplier : operand pair stream into the FIFO
//   mul_start/mul_mcand/mul_mplier       : issue side towards the Booth controller/datapath
//   mul_done/mul_product                 : completion pulse and {A,Q} product
//   out_valid/out_ready/out_product      : registered result stream
interface booth_mul_sequencer_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_mcand;
  logic [WIDTH-1:0]   in_mplier;
  logic               mul_start;
  logic [WIDTH-1:0]   mul_mcand;
  logic [WIDTH-1:0]   mul_mplier;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_product;

  modport slave (
    input  in_valid, in_mcand, in_mplier, mul_done, mul_product, out_ready,
    output in_ready, mul_start, mul_mcand, mul_mplier, out_valid, out_product
  );

  modport master (
    output in_valid, in_mcand, in_mplier, mul_done, mul_product, out_ready,
    input  in_ready, mul_start, mul_mcand, mul_mplier, out_valid, out_product
  );
endinterface

// File: rtl/booth_mul_sequencer.sv
// rtl/booth_mul_sequencer.sv - operand FIFO, issue FSM and result register in front of a Booth multiplier
//
// Purpose: buffers signed operand pairs, issues them one at a time to the Booth
//   controller (1-cycle mul_start, operands held until done), captures the product
//   on mul_done and presents it on a valid/ready result port. A missing done within
//   TIMEOUT cycles of the start cycle drops the op and sets a sticky err flag.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : booth_mul_sequencer_if.slave (operand, issue and result handshakes)
//   busy  : FIFO non-empty, FSM not idle, or a result is pending
//   err   : sticky timeout flag, cleared only by reset
// Optional feature: BOOTH_SEQ_ZERO_BYPASS_EN - ops with a zero operand complete
//   directly from IDLE with a zero product and never reach the controller.
module booth_mul_sequencer #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 2,
  parameter int TIMEOUT    = 40
) (
  input  logic                clk,
  input  logic                rst_n,
  booth_mul_sequencer_if.slave bus,
  output logic                busy,
  output logic                err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t               state_q, state_d;
  logic [PW:0]          wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0]     mcand_mem [FIFO_DEPTH];
  logic [WIDTH-1:0]     mplier_mem [FIFO_DEPTH];
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic                 out_valid_q, out_valid_d;
  logic [2*WIDTH-1:0]   out_product_q, out_product_d;
  logic                 err_q, err_d;
  logic                 rdy_en_q;
  logic                 empty, full, push, pop, start;
  logic [WIDTH-1:0]     head_mcand, head_mplier;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign full        = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign push        = bus.in_valid && bus.in_ready;
  assign head_mcand  = mcand_mem[rd_ptr_q[PW-1:0]];
  assign head_mplier = mplier_mem[rd_ptr_q[PW-1:0]];

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mcand_d       = mcand_q;
    mplier_d      = mplier_q;
    out_valid_d   = out_valid_q && !bus.out_ready;
    out_product_d = out_product_q;
    err_d         = err_q;
    pop           = 1'b0;
    start         = 1'b0;
    case (state_q)
      IDLE: begin
        // Issue only with a free output register so the product always has a home at done.
        if (!empty && (!out_valid_q || bus.out_ready)) begin
          pop = 1'b1;
`ifdef BOOTH_SEQ_ZERO_BYPASS_EN
          if (head_mcand == '0 || head_mplier == '0) begin
            out_product_d = '0;
            out_valid_d   = 1'b1;
          end else begin
            mcand_d  = head_mcand;
            mplier_d = head_mplier;
            state_d  = ISSUE;
          end
`else
          mcand_d  = head_mcand;
          mplier_d = head_mplier;
          state_d  = ISSUE;
`endif
        end
      end
      ISSUE: begin
        start   = 1'b1;
        // Counter holds cycles elapsed since the start cycle.
        cnt_d   = CW'(1);
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.mul_done) begin
          out_product_d = bus.mul_product;
          out_valid_d   = 1'b1;
          state_d       = IDLE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // err becomes visible exactly TIMEOUT cycles after the start cycle.
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      mcand_q       <= '0;
      mplier_q      <= '0;
      out_valid_q   <= 1'b0;
      out_product_q <= '0;
      err_q         <= 1'b0;
      rdy_en_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mcand_q       <= mcand_d;
      mplier_q      <= mplier_d;
      out_valid_q   <= out_valid_d;
      out_product_q <= out_product_d;
      err_q         <= err_d;
      rdy_en_q      <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset; only the pointers define occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      mcand_mem[wr_ptr_q[PW-1:0]]  <= bus.in_mcand;
      mplier_mem[wr_ptr_q[PW-1:0]] <= bus.in_mplier;
    end
  end

  // in_ready stays low while reset is asserted and rises on the first edge after release.
  assign bus.in_ready    = rdy_en_q && !full;
  assign bus.mul_start   = start;
  assign bus.mul_mcand   = mcand_q;
  assign bus.mul_mplier  = mplier_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_product = out_product_q;
  assign busy            = !empty || (state_q != IDLE) || out_valid_q;
  assign err             = err_q;
endmodule
